psc_trigger: RTL and testbench
==============================

# psc_trigger

Converts an active-low timing-system (EVR) trigger pulse into a fixed serial broadcast command frame on a UART-style TX line driving the power-supply controllers (PSC). Sits between the EVR trigger input pin and the RS-485 transmitter, and runs entirely in the single system clock domain (50 MHz nominal, 100 MHz build variant).

## Interface
- CLK_DIV, 8: clock cycles per serial bit (50 MHz / 8 = 6.25 Mbaud); must be ≥ 2.
- FUNC_ID, 8'h00: function-ID byte carried in the frame.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; released synchronously to clk.
- evr_trigger  input  1  asynchronous EVR trigger, idle high, active-low pulse.
- psc_output  output  1  serial TX line, idle high.

## Operation
- evr_trigger is passed through a 2-flop synchronizer reset to 1, then a previous-value register reset to 1. A trigger event is synchronized value 0 with previous value 1 (falling edge).
- The frame is 6 bytes, sent in order: 8'hFF (broadcast address), 8'h50 (execute function), 8'h00, 8'h01 (payload size), FUNC_ID, checksum.
- Checksum = (0 − sum of the first 5 bytes) mod 256. With FUNC_ID = 8'h00, checksum = 8'hB0, so all 6 bytes sum to 0 mod 256.
- Each byte is sent 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1). Each bit is exactly CLK_DIV cycles. Bytes are back-to-back with no idle gap.
- FSM states:
  - IDLE: psc_output = 1. Goes to SEND on a trigger event.
  - SEND: shifts out bytes 0..5. After the stop bit of byte 5 completes, returns to IDLE.
- Trigger events while in SEND are discarded, not queued.
- A held-low trigger produces exactly one frame. A new frame needs evr_trigger to go high and then low again.
- Pulses shorter than one clk period may be missed. This is accepted.

## Timing
- Reset values: psc_output = 1, FSM = IDLE, synchronizer and edge registers = 1, byte index, bit counter and divider counter = 0.
- Reset asserted mid-frame aborts the frame immediately and forces psc_output high. After release, no frame is sent until a fresh falling edge of evr_trigger.
- Latency: cycle N is the first rising edge that samples evr_trigger = 0. psc_output goes low (start bit) at edge N+3 and is registered, glitch-free.
- Frame length = 60 × CLK_DIV cycles: 480 cycles (9.6 µs) at the defaults.
- The next frame can start on the cycle after the final stop bit ends.

## Structure
- Shared package psc_trigger_pkg holds:
  - frame constants: ADDR_BCAST = 8'hFF, CMD_EXEC = 8'h50, SIZE_HI = 8'h00, SIZE_LO = 8'h01, FRAME_LEN = 6;
  - the FSM state enum.
- One sub-module, psc_uart_tx, contains the bit-rate divider and the 10-bit shifter, with a start/busy handshake.
  - start is sampled only when busy = 0.
  - busy rises on the cycle after start.
- The top level holds the synchronizer, edge detector, frame sequencer and checksum constant.

## Test plan
- Reset hold: reset = 0 for 1 µs with evr_trigger = 1 -> psc_output stays 1 throughout; no activity after release.
- Single trigger at 50 MHz: evr_trigger low at 15 µs for 6 µs -> start bit exactly 3 clk edges after the first low sample. Decoded bytes are FF 50 00 01 00 B0, each bit 8 cycles, frame 480 cycles, then psc_output = 1.
- Held trigger: evr_trigger low for 20 µs -> exactly one frame.
- Retrigger while busy: a second falling edge 2 µs into a frame -> ignored, only one frame sent. A falling edge 1 cycle after frame end -> second identical frame starts.
- Mid-frame reset: reset = 0 at byte 2 -> psc_output = 1 asynchronously. After release, no output until the next falling edge, which yields a full frame.
- Parameter check: FUNC_ID = 8'h0C, CLK_DIV = 16 -> bytes FF 50 00 01 0C A4, 16-cycle bits.

Source files
------------

// File: rtl/psc_trigger_pkg.sv
// Shared definitions for the PSC trigger broadcaster.
// Holds the fixed frame bytes, the frame length, the sequencer state type
// and the checksum helper used to build the final byte of the frame.
package psc_trigger_pkg;

    // Fixed bytes of the "execute function" broadcast frame.
    localparam logic [7:0]  ADDR_BCAST = 8'hFF;
    localparam logic [7:0]  CMD_EXEC   = 8'h50;
    localparam logic [7:0]  SIZE_HI    = 8'h00;
    localparam logic [7:0]  SIZE_LO    = 8'h01;
    localparam int unsigned FRAME_LEN  = 6;

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

    // Two's-complement checksum: all six frame bytes sum to zero mod 256.
    function automatic logic [7:0] frame_checksum(input logic [7:0] func_id);
        logic [7:0] sum;
        sum = ADDR_BCAST + CMD_EXEC + SIZE_HI + SIZE_LO + func_id;
        return 8'(8'h00 - sum);
    endfunction

endpackage

// File: rtl/psc_uart_tx.sv
// 8N1 serial transmitter with a bit-rate divider.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   start  load request for data; sampled only while busy is low
//   data   byte to send, LSB first
//   busy   high while a byte is in flight; rises the cycle after start
//   tx     registered serial line, idle high
//
// busy drops during the final cycle of the stop bit so that a start issued
// in that cycle puts the next start bit on the line with no idle gap.
module psc_uart_tx #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]      BIT_LAST = 4'd9;

    logic             active_q, active_d;
    logic             tx_q, tx_d;
    // Bits still to be sent after the current one (data then stop bit).
    logic [8:0]       shift_q, shift_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             bit_end;
    logic             last_cycle;

    assign bit_end    = (div_cnt_q == DIV_LAST);
    assign last_cycle = active_q && bit_end && (bit_cnt_q == BIT_LAST);
    assign busy       = active_q && !last_cycle;
    assign tx         = tx_q;

    always_comb begin
        active_d  = active_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (start && !busy) begin
            active_d  = 1'b1;
            tx_d      = 1'b0;
            shift_d   = {1'b1, data};
            div_cnt_d = '0;
            bit_cnt_d = '0;
        end else if (active_q) begin
            if (bit_end) begin
                div_cnt_d = '0;
                if (bit_cnt_q == BIT_LAST) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b1, shift_q[8:1]};
                end
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q  <= 1'b0;
            tx_q      <= 1'b1;
            shift_q   <= '1;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            active_q  <= active_d;
            tx_q      <= tx_d;
            shift_q   <= shift_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/psc_trigger.sv
// EVR trigger to PSC broadcast command converter.
// A falling edge on the (asynchronous, active-low) EVR trigger sends one
// fixed 6-byte "execute function" frame on the serial TX line.
//
// Parameters:
//   CLK_DIV  clock cycles per serial bit (>= 2)
//   FUNC_ID  function-ID byte carried in the frame
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   evr_trigger  asynchronous trigger input, idle high, active low
//   psc_output   serial TX line to the RS-485 driver, idle high
module psc_trigger
    import psc_trigger_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8,
    parameter logic [7:0]  FUNC_ID = 8'h00
) (
    input  logic clk,
    input  logic reset,
    input  logic evr_trigger,
    output logic psc_output
);

    localparam logic [7:0] CHECKSUM  = frame_checksum(FUNC_ID);
    localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       trig_event;

    state_e     state_q, state_d;
    logic [2:0] byte_idx_q, byte_idx_d;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_busy;

    // Two-flop synchronizer plus previous-value register, all idling high so
    // that reset release never looks like a falling edge on an idle input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], evr_trigger};
            prev_q <= sync_q[1];
        end
    end

    assign trig_event = !sync_q[1] && prev_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; triggers seen while sending are simply dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (trig_event) state_d = StSend;
            StSend: if (!tx_busy && (byte_idx_q == LAST_IDX)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: hand the transmitter a new byte whenever it can accept one.
    always_comb begin
        tx_start = (state_q == StSend) && !tx_busy && (byte_idx_q != LAST_IDX);
        unique case (byte_idx_q)
            3'd0:    tx_byte = ADDR_BCAST;
            3'd1:    tx_byte = CMD_EXEC;
            3'd2:    tx_byte = SIZE_HI;
            3'd3:    tx_byte = SIZE_LO;
            3'd4:    tx_byte = FUNC_ID;
            3'd5:    tx_byte = CHECKSUM;
            default: tx_byte = 8'hFF;
        endcase
    end

    // Byte index: advances on each accepted byte, cleared while idle.
    always_comb begin
        byte_idx_d = byte_idx_q;
        if (state_q == StIdle) begin
            byte_idx_d = '0;
        end else if (tx_start) begin
            byte_idx_d = byte_idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx_q <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
        end
    end

    psc_uart_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_uart_tx (
        .clk  (clk),
        .reset(reset),
        .start(tx_start),
        .data (tx_byte),
        .busy (tx_busy),
        .tx   (psc_output)
    );

endmodule

// File: tb/tb_psc_trigger.sv
module tb_psc_trigger;

    typedef struct {
        logic [7:0] data;
        int         t;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic evr_a, evr_b;
    logic psc_a, psc_b;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   k;

    exp_t exp_a[$];
    exp_t exp_b[$];

    logic [7:0] frame_a [6] = '{8'hFF, 8'h50, 8'h00, 8'h01, 8'h00, 8'hB0};
    logic [7:0] frame_b [6] = '{8'hFF, 8'h50, 8'h00, 8'h01, 8'h0C, 8'hA4};

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    psc_trigger #(
        .CLK_DIV(8),
        .FUNC_ID(8'h00)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .evr_trigger(evr_a),
        .psc_output (psc_a)
    );

    psc_trigger #(
        .CLK_DIV(16),
        .FUNC_ID(8'h0C)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .evr_trigger(evr_b),
        .psc_output (psc_b)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic push_frame(input int sel, input int t0, input int nbytes);
        exp_t e;
        int   div;
        div = (sel == 0) ? 8 : 16;
        for (int i = 0; i < nbytes; i++) begin
            e.data = (sel == 0) ? frame_a[i] : frame_b[i];
            e.t    = t0 + i * 10 * div;
            if (sel == 0) exp_a.push_back(e);
            else exp_b.push_back(e);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Decodes bytes off one TX line; checks start time, bit widths, framing
    // and data against the expected queue.
    task automatic monitor(input int sel);
        exp_t       e;
        int         div;
        int         t;
        logic [9:0] bits;
        logic       line;
        bit         have;
        bit         stable;
        bit         aborted;
        div = (sel == 0) ? 8 : 16;
        forever begin
            @(negedge clk);
            line = (sel == 0) ? psc_a : psc_b;
            if (reset && line == 1'b0) begin
                t    = cyc;
                have = (sel == 0) ? (exp_a.size() > 0) : (exp_b.size() > 0);
                if (have) begin
                    e = (sel == 0) ? exp_a.pop_front() : exp_b.pop_front();
                    check($sformatf("start_time_%0d", sel), t, e.t);
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start_%0d actual=cycle %0d required=idle", sel, t);
                end
                bits    = '1;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < div && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        line = (sel == 0) ? psc_a : psc_b;
                        if (!reset) aborted = 1'b1;
                        else if (c == 0) bits[b] = line;
                        else if (line != bits[b]) stable = 1'b0;
                    end
                end
                if (!aborted && have) begin
                    check($sformatf("data_%0d", sel), int'(bits[8:1]), int'(e.data));
                    check($sformatf("framing_%0d", sel), {stable, bits[9], bits[0]}, 3'b110);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        reset = 1'b0;
        evr_a = 1'b1;
        evr_b = 1'b1;
        // Reset hold: line must stay high.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i % 10 == 5) begin
                check("reset_hold_a", psc_a, 1);
                check("reset_hold_b", psc_b, 1);
            end
        end
        reset = 1'b1;
        repeat (50) @(negedge clk);
        check("post_release_idle_a", psc_a, 1);
        check("post_release_idle_b", psc_b, 1);

        // Single trigger.
        k = cyc;
        evr_a = 1'b0;
        push_frame(0, k + 4, 6);
        wait_until(k + 300);
        evr_a = 1'b1;
        wait_until(k + 484);
        check("frame_end_high", psc_a, 1);
        wait_until(k + 600);

        // Held trigger: exactly one frame.
        k = cyc;
        evr_a = 1'b0;
        push_frame(0, k + 4, 6);
        wait_until(k + 1000);
        evr_a = 1'b1;
        wait_until(k + 1100);
        check("held_idle", psc_a, 1);

        // Retrigger while busy is ignored; retrigger right after frame end is not.
        k = cyc;
        evr_a = 1'b0;
        push_frame(0, k + 4, 6);
        wait_until(k + 90);
        evr_a = 1'b1;
        wait_until(k + 100);
        evr_a = 1'b0;
        wait_until(k + 200);
        evr_a = 1'b1;
        wait_until(k + 484);
        evr_a = 1'b0;
        push_frame(0, k + 488, 6);
        wait_until(k + 520);
        evr_a = 1'b1;
        wait_until(k + 488 + 480 + 50);
        check("retrigger_idle", psc_a, 1);

        // Mid-frame reset during byte 2 (all-zero data bits).
        k = cyc;
        evr_a = 1'b0;
        push_frame(0, k + 4, 3);
        wait_until(k + 20);
        evr_a = 1'b1;
        wait_until(k + 180);
        check("pre_reset_low", psc_a, 0);
        #1 reset = 1'b0;
        #1 check("async_reset_high", psc_a, 1);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        check("post_abort_idle", psc_a, 1);
        check("abort_queue_empty", exp_a.size(), 0);
        k = cyc;
        evr_a = 1'b0;
        push_frame(0, k + 4, 6);
        wait_until(k + 50);
        evr_a = 1'b1;
        wait_until(k + 550);

        // Alternate parameters: FUNC_ID 0x0C, 16 cycles per bit.
        k = cyc;
        evr_b = 1'b0;
        push_frame(1, k + 4, 6);
        wait_until(k + 300);
        evr_b = 1'b1;
        wait_until(k + 4 + 960 + 50);
        check("param_idle", psc_b, 1);

        check("leftover_a", exp_a.size(), 0);
        check("leftover_b", exp_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
